// File: rtl/dma_priority_arbiter.sv
// DMA channel arbiter with HRQ/HLDA hold handshake; registered HRQ/DACK, DREQ->HRQ in 1 cycle.
// Optional DMA_DREQ_SYNC_EN adds a 2-flop DREQ synchronizer (+2 cycles); no backpressure beyond HLDA.
module dma_priority_arbiter #(
    parameter logic [7:0]  PRIO_RESET  = 8'b11_10_01_00,
    parameter int unsigned HRQ_MIN_LOW = 1
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [3:0] DREQ,
    input  logic       HLDA,
    input  logic [3:0] maskReg,
    input  logic       priorityType,
    input  logic       dreqSense,
    input  logic       dackSense,
    input  logic       controllerDisable,
    input  logic       assertDACK,
    input  logic       transferDone,
    output logic       HRQ,
    output logic [3:0] DACK,
    output logic       grantValid,
    output logic [1:0] grantChannel,
    output logic [7:0] priorityOrder
);

    typedef enum logic [1:0] {IDLE, HOLD_REQ, SERVICE, RELEASE} state_t;

    state_t     state_q, state_d;
    logic       hrq_q, hrq_d;
    logic [3:0] dack_q, dack_d;
    logic [1:0] gch_q, gch_d;
    logic [7:0] order_q, order_d;
    logic       mode_q, mode_d;
    logic [3:0] low_cnt_q, low_cnt_d;

    logic [3:0] dreq_eff;
    logic [3:0] req;
    logic [7:0] sel_order;
    logic [7:0] rot_order;
    logic [1:0] winner;
    logic       low_done;

`ifdef DMA_DREQ_SYNC_EN
    logic [3:0] dreq_s1_q, dreq_s2_q;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            dreq_s1_q <= '0;
            dreq_s2_q <= '0;
        end else begin
            dreq_s1_q <= DREQ;
            dreq_s2_q <= dreq_s1_q;
        end
    end

    assign dreq_eff = dreq_s2_q;
`else
    assign dreq_eff = DREQ;
`endif

    assign req       = controllerDisable ? 4'b0000 : ((dreq_eff ^ {4{dreqSense}}) & ~maskReg);
    assign sel_order = priorityType ? order_q : PRIO_RESET;
    // Serviced channel drops to the lowest field; the others keep their cyclic order.
    assign rot_order = {gch_q, gch_q + 2'd3, gch_q + 2'd2, gch_q + 2'd1};
    assign low_done  = (low_cnt_q >= 4'(HRQ_MIN_LOW - 1));

    // Scan from lowest to highest priority so the highest-priority requester wins;
    // with no request left the top-priority channel is latched.
    always_comb begin
        winner = sel_order[1:0];
        for (int i = 3; i >= 0; i--) begin
            if (req[sel_order[2*i +: 2]]) begin
                winner = sel_order[2*i +: 2];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        gch_d     = gch_q;
        mode_d    = mode_q;
        order_d   = order_q;
        low_cnt_d = '0;
        dack_d    = {4{dackSense}};

        if (state_q != SERVICE && !priorityType) begin
            order_d = PRIO_RESET;
        end

        case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d = HOLD_REQ;
                end
            end
            HOLD_REQ: begin
                if (HLDA) begin
                    state_d = SERVICE;
                    gch_d   = winner;
                    mode_d  = priorityType;
                end else if (!(|req)) begin
                    state_d = IDLE;
                end
            end
            SERVICE: begin
                if (transferDone) begin
                    state_d = RELEASE;
                    if (mode_q) begin
                        order_d = rot_order;
                    end
                end else if (!HLDA) begin
                    state_d = RELEASE;
                end else begin
                    dack_d[gch_q] = assertDACK ^ dackSense;
                end
            end
            RELEASE: begin
                low_cnt_d = low_done ? low_cnt_q : low_cnt_q + 4'd1;
                if (low_done && !HLDA) begin
                    state_d   = IDLE;
                    low_cnt_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase

        hrq_d = (state_d == HOLD_REQ) || (state_d == SERVICE);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= IDLE;
            hrq_q     <= 1'b0;
            dack_q    <= 4'b0000;
            gch_q     <= 2'd0;
            order_q   <= PRIO_RESET;
            mode_q    <= 1'b0;
            low_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            hrq_q     <= hrq_d;
            dack_q    <= dack_d;
            gch_q     <= gch_d;
            order_q   <= order_d;
            mode_q    <= mode_d;
            low_cnt_q <= low_cnt_d;
        end
    end

    assign HRQ           = hrq_q;
    assign DACK          = dack_q;
    assign grantValid    = (state_q == SERVICE);
    assign grantChannel  = gch_q;
    assign priorityOrder = order_q;

endmodule
